// File: rtl/bcd_entry_to_bin_pkg.sv
// Shared types and constants for the BCD-entry to binary converter.
// The saturating output build is selected with BCD2BIN_SATURATE_EN in the top.
package bcd_entry_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int                   BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX    = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] FIX_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] FIX_SUB    = 4'd3;

    // Width of a counter that has to reach n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_entry_to_bin_sub3.sv
// One reverse double-dabble correction cell: a nibble at or above 8 after a
// right shift has borrowed a ten-weight bit that belongs in the digit below.
module bcd_entry_to_bin_sub3
    import bcd_entry_to_bin_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] fixed
);

    // Subtract-3 correction, the inverse of the display path's add-3 cell.
    always_comb begin
        fixed = digit;
        if (digit >= FIX_THRESH) begin
            fixed = digit - FIX_SUB;
        end else begin
            fixed = digit;
        end
    end

endmodule

// File: rtl/bcd_entry_to_bin.sv
// Sequential packed-BCD to binary converter, one accumulator bit per clock.
// Build option: define BCD2BIN_SATURATE_EN to clamp bin_out to all ones on overflow.
module bcd_entry_to_bin
    import bcd_entry_to_bin_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int INT_W    = 10,
    parameter int OUT_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_in,
    output logic                            busy,
    output logic                            done,
    output logic [OUT_W-1:0]                bin_out,
    output logic                            overflow,
    output logic                            bad_digit
);

    localparam int               BCD_W   = BCD_DIGIT_W * N_DIGITS;
    localparam int               CNT_W   = cnt_width(INT_W);
    localparam logic [INT_W-1:0] OUT_MAX = INT_W'((2 ** OUT_W) - 1);

    conv_state_t      state_r, state_s;
    logic [BCD_W-1:0] bcd_r, bcd_s;
    logic [INT_W-1:0] acc_r, acc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             bad_r, bad_s;

    logic [BCD_W-1:0] shift_bcd_s;
    logic [BCD_W-1:0] fix_bcd_s;
    logic [INT_W-1:0] shift_acc_s;
    logic             ovf_s;
    logic [OUT_W-1:0] result_s;

    logic             busy_r, done_r, overflow_r, bad_digit_r;
    logic [OUT_W-1:0] bin_out_r;

    function automatic logic any_bad_nibble(input logic [BCD_W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    assign shift_bcd_s = bcd_r >> 1;
    assign shift_acc_s = {bcd_r[0], acc_r[INT_W-1:1]};

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_fix
        bcd_entry_to_bin_sub3 u_sub3 (
            .digit (shift_bcd_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .fixed (fix_bcd_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign ovf_s = (acc_r > OUT_MAX);

`ifdef BCD2BIN_SATURATE_EN
    assign result_s = ovf_s ? {OUT_W{1'b1}} : acc_r[OUT_W-1:0];
`else
    assign result_s = acc_r[OUT_W-1:0];
`endif

    // State, working register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            bcd_r   <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            bad_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            bcd_r   <= bcd_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            bad_r   <= bad_s;
        end
    end

    // Next state and datapath. An invalid entry spends one SHIFT cycle without
    // shifting so the result is decided from the captured digits, not live input.
    always_comb begin
        state_s = state_r;
        bcd_s   = bcd_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        bad_s   = bad_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    bcd_s   = bcd_in;
                    acc_s   = '0;
                    cnt_s   = '0;
                    bad_s   = any_bad_nibble(bcd_in);
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bad_r) begin
                    state_s = DONE;
                end else begin
                    bcd_s = fix_bcd_s;
                    acc_s = shift_acc_s;
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(INT_W - 1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bin_out_r   <= '0;
            overflow_r  <= 1'b0;
            bad_digit_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_r == DONE);
            if (state_r == DONE) begin
                bin_out_r   <= bad_r ? '0 : result_s;
                overflow_r  <= !bad_r && ovf_s;
                bad_digit_r <= bad_r;
            end else begin
                bin_out_r   <= bin_out_r;
                overflow_r  <= overflow_r;
                bad_digit_r <= bad_digit_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign bin_out   = bin_out_r;
    assign overflow  = overflow_r;
    assign bad_digit = bad_digit_r;

endmodule
